// File: rtl/gcd_binary_engine_if.sv
// Command/result bundle for gcd_binary_engine.
// op_cnt is present only when GCD_OP_COUNT_EN is defined.
interface gcd_binary_engine_if #(
  parameter int OP_SZ  = 8,
  parameter int CNT_SZ = 8
);
  logic              start;
  logic [OP_SZ-1:0]  A;
  logic [OP_SZ-1:0]  B;
  logic              busy;
  logic              done;
  logic [OP_SZ-1:0]  res;
`ifdef GCD_OP_COUNT_EN
  logic [CNT_SZ-1:0] op_cnt;

  modport master (output start, A, B, input busy, done, res, op_cnt);
  modport slave  (input start, A, B, output busy, done, res, op_cnt);
`else
  modport master (output start, A, B, input busy, done, res);
  modport slave  (input start, A, B, output busy, done, res);
`endif

  if (OP_SZ < 2 || OP_SZ > 64 || CNT_SZ < 1) begin : g_param_chk
    $error("gcd_binary_engine_if: OP_SZ must be 2..64 and CNT_SZ >= 1");
  end
endinterface

// File: rtl/gcd_binary_engine.sv
// Multi-cycle binary (Stein) GCD engine: shifts and subtracts only, one step per cycle.
// Optional saturating step counter on op_cnt when GCD_OP_COUNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; also hosts the done cycle (busy still high)
// STRIP  | removing common factors of two, counted in k
// REDUCE | Stein reduction until a==b, then a <= a<<k
// FINISH | a holds the result; load res and pulse done
module gcd_binary_engine #(
  parameter int OP_SZ  = 8,
  parameter int CNT_SZ = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gcd_binary_engine_if.slave   bus
);
  localparam int KW = $clog2(OP_SZ);

  typedef enum logic [1:0] {IDLE, STRIP, REDUCE, FINISH} state_t;

  state_t           state_q, state_d;
  logic [OP_SZ-1:0] a_q, a_d;
  logic [OP_SZ-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [OP_SZ-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  if (OP_SZ < 2 || OP_SZ > 64 || CNT_SZ < 1) begin : g_param_chk
    $error("gcd_binary_engine: OP_SZ must be 2..64 and CNT_SZ >= 1");
  end

  assign accept = (state_q == IDLE) && bus.start && !busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // busy_q is only high here during the done cycle, so it drops next cycle
        busy_d = 1'b0;
        if (accept) begin
          busy_d = 1'b1;
          a_d    = bus.A;
          b_d    = bus.B;
          k_d    = '0;
          if (bus.A == '0 || bus.B == '0) begin
            a_d     = bus.A | bus.B;
            state_d = FINISH;
          end else begin
            state_d = STRIP;
          end
        end
      end
      STRIP: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (a_q == b_q) begin
          a_d     = a_q << k_q;
          state_d = FINISH;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end
      FINISH: begin
        res_d   = a_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;

`ifdef GCD_OP_COUNT_EN
  logic [CNT_SZ-1:0] cnt_q, op_cnt_q;
  logic              step;

  // every STRIP shift and every REDUCE cycle except the a==b exit modifies a or b
  assign step = ((state_q == STRIP) && !a_q[0] && !b_q[0]) ||
                ((state_q == REDUCE) && (a_q != b_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      if (accept)
        cnt_q <= '0;
      else if (step && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_SZ'(1);
      if (state_q == FINISH)
        op_cnt_q <= cnt_q;
    end
  end

  assign bus.op_cnt = op_cnt_q;
`endif
endmodule

// File: tb/tb_gcd_binary_engine.sv
// Scoreboard bench for gcd_binary_engine at OP_SZ=16, CNT_SZ=4 (small counter exercises saturation).
module tb_gcd_binary_engine;
  localparam int OP_SZ  = 16;
  localparam int CNT_SZ = 4;

  typedef struct {
    logic [15:0] res;
    int          cnt;
    int          acc;
    int          lo;
    int          hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_pushed = 0;
  int   last_done_cyc = 0;
  bit   prev_done = 1'b0;
  exp_t sb[$];

  gcd_binary_engine_if #(.OP_SZ(OP_SZ), .CNT_SZ(CNT_SZ)) bus ();

  gcd_binary_engine #(.OP_SZ(OP_SZ), .CNT_SZ(CNT_SZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (prev_done) begin
      chk("busy_low_after_done", bus.busy, 0);
      chk("done_single_cycle", bus.done, 0);
    end
    prev_done = bus.done;
    if (bus.done) begin
      n_done++;
      last_done_cyc = cyc;
      chk("busy_high_in_done", bus.busy, 1);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got res %0d expected no done (cycle %0d)", bus.res, cyc);
      end else begin
        e = sb.pop_front();
        chk("res", bus.res, e.res);
`ifdef GCD_OP_COUNT_EN
        chk("op_cnt", bus.op_cnt, e.cnt);
`endif
        lat = cyc - e.acc;
        n_tests++;
        if (lat < e.lo || lat > e.hi) begin
          n_fail++;
          $display("FAIL latency: got %0d expected %0d..%0d", lat, e.lo, e.hi);
        end
      end
    end
  end

  task automatic wait_not_busy();
    int g = 0;
    while (bus.busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                       input int cnt, input int lo, input int hi, input bit push);
    exp_t e;
    wait_not_busy();
    if (push) begin
      e.res = r; e.cnt = cnt; e.acc = cyc; e.lo = lo; e.hi = hi;
      sb.push_back(e);
      n_pushed++;
    end
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || bus.busy) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0 || bus.busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input int cnt, input int lo, input int hi);
    issue(a, b, r, cnt, lo, hi, 1'b1);
    wait_idle();
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_res", bus.res, 0);
`ifdef GCD_OP_COUNT_EN
    chk("reset_op_cnt", bus.op_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(16'd48,  16'd18,  16'd6,   5, 3, 35);
    run_op(16'd12,  16'd18,  16'd6,   3, 3, 35);
    run_op(16'd17,  16'd5,   16'd1,   4, 3, 35);
    run_op(16'd200, 16'd200, 16'd200, 3, 3, 35);

    run_op(16'd0, 16'd5, 16'd5, 0, 2, 2);
    run_op(16'd9, 16'd0, 16'd9, 0, 2, 2);
    run_op(16'd0, 16'd0, 16'd0, 0, 2, 2);

    // 30 and 15 steps: counter saturates at 15 in both
    run_op(16'hFFFF, 16'h8000, 16'd1,    15, 3, 35);
    run_op(16'h8000, 16'h4000, 16'h4000, 15, 3, 35);

    // start while busy with other operands must be ignored
    issue(16'd48, 16'd18, 16'd6, 5, 3, 35, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'd100;
    bus.B     = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // start held high: back-to-back with one idle cycle between
    bus.start = 1'b1;
    bus.A     = 16'd12;
    bus.B     = 16'd18;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      wait_not_busy();
      if (i > 0) chk("one_idle_cycle", cyc - last_done_cyc, 1);
      e.res = 16'd6; e.cnt = 3; e.acc = cyc; e.lo = 3; e.hi = 35;
      sb.push_back(e);
      n_pushed++;
      @(negedge clk);
      if (i == 2) bus.start = 1'b0;
    end
    wait_idle();

    // reset in the middle of REDUCE aborts without a done pulse
    issue(16'hFFFF, 16'h8000, 16'd0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_res", bus.res, 0);
    chk("abort_done", bus.done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_op(16'd48, 16'd18, 16'd6, 5, 3, 35);

    repeat (4) @(negedge clk);
    chk("done_count", n_done, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gcd_binary_engine.md
Name: gcd_binary_engine

Overview:
- Parametrised multi-cycle GCD engine using the binary (Stein) algorithm: shifts and subtract only, no divider.
- Successor to the current subtract-only GCD controller. Adds:
  - a generic operand width
  - defined zero-operand handling
  - a busy/accept handshake
  - a one-operation-per-cycle datapath with common-power-of-two extraction
- Sits between the register-file/command interface and any consumer of the GCD result.

Parameters:
- OP_SZ, 8, operand and result width in bits (legal range 2..64).
- CNT_SZ, 8, width of the optional operation counter (saturates; see Optional Feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request. Accepted on a rising edge when start=1 and busy=0.
- A  input  OP_SZ  operand A, sampled only on the accepting edge.
- B  input  OP_SZ  operand B, sampled only on the accepting edge.
- busy  output  1  high from the cycle after acceptance through the cycle done is high.
- done  output  1  one-cycle pulse: res is valid.
- res  output  OP_SZ  GCD result. Held until the next accepted start.
- op_cnt  output  CNT_SZ  operation count. Present only with GCD_OP_COUNT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, res=0, internal a/b/k=0, op_cnt=0.
  - A reset asserted mid-operation aborts it: no done pulse, res cleared.
- All outputs are registered.
- States: IDLE, STRIP, REDUCE, FINISH.
- IDLE:
  - start=1 latches a=A, b=B, k=0.
  - If A==0 or B==0, go to FINISH with pending result A|B (gcd(0,0)=0).
  - Otherwise go to STRIP.
- STRIP, one cycle per step:
  - If a[0]==0 and b[0]==0: a>>=1, b>>=1, k+=1.
  - Else go to REDUCE, operands unchanged.
- REDUCE, one action per cycle, in this priority:
  1. a==b: pending result = a<<k, go to FINISH.
  2. a[0]==0: a>>=1.
  3. b[0]==0: b>>=1.
  4. a>b: a=(a-b)>>1.
  5. else b=(b-a)>>1.
- Width rules:
  - Subtraction is unsigned and never underflows.
  - k never exceeds OP_SZ-1.
  - a<<k never exceeds min(A,B), so res fits OP_SZ bits without truncation.
- FINISH: res<=pending result, done<=1 for exactly one cycle, then IDLE.
  - busy is still 1 in the FINISH/done cycle and drops the following cycle.
- Handshake:
  - start while busy=1 is ignored (not queued).
  - start held high continuously re-triggers on the first IDLE edge after done, giving back-to-back operations with one idle cycle.
  - A/B changes while busy have no effect.
- Latency: depends on the data.
  - Zero operand: done 2 cycles after the accepting edge.
  - Worst case is bounded by 2*OP_SZ+3 cycles.

Optional Feature:
- Macro: GCD_OP_COUNT_EN.
- Defined:
  - op_cnt exists.
  - Cleared on accept.
  - Incremented on every STRIP shift and every REDUCE step that modifies a or b.
  - Saturates at 2^CNT_SZ-1.
  - Registered with res; valid when done=1.
- Undefined: the op_cnt port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset during idle, then A=48, B=18, start pulse -> done pulse, res=6, busy low the cycle after done. With GCD_OP_COUNT_EN, op_cnt=5.
- A=12, B=18 -> res=6 (op_cnt=3). Then A=17, B=5 (coprime) -> res=1. Then A=200, B=200 -> res=200 (op_cnt=3).
- Zero cases: A=0, B=5 -> res=5; A=9, B=0 -> res=9; A=0, B=0 -> res=0. Each asserts done exactly 2 cycles after acceptance, with op_cnt=0.
- OP_SZ=16, A=0xFFFF, B=0x8000 -> res=1 within 35 cycles. A=0x8000, B=0x4000 -> res=0x4000.
- Start pulsed while busy with different operands -> ignored; first result unchanged, exactly one done pulse.
- Start held high continuously -> back-to-back results, each separated by one idle cycle.
- rst asserted mid-REDUCE -> next cycle busy=0, res=0, no done. A new start afterwards computes correctly.
